// File: rtl/truth_table_sweeper_pkg.sv
// Shared types and defaults for the truth-table sweeper slice.
package sweeper_pkg;

   typedef enum logic [1:0] {IDLE, DRIVE, DONE} state_t;

   localparam logic [15:0] DEF_SIG_POLY = 16'h1021;
   localparam logic [15:0] DEF_SIG_SEED = 16'h0000;

   function automatic logic [31:0] bin2gray(input logic [31:0] b);
      return b ^ (b >> 1);
   endfunction

endpackage

// File: rtl/truth_table_sweeper_if.sv
// Control/stimulus/response bundle between lab control (master) and sweeper (slave).
interface truth_table_sweeper_if #(
   parameter int N_IN  = 3,
   parameter int N_OUT = 2,
   parameter int SIG_W = 16
);
   logic             start;
   logic             abort;
   logic             gray_mode;
   logic [N_OUT-1:0] resp;
   logic [N_IN-1:0]  stim;
   logic             busy;
   logic             sample_valid;
   logic [N_IN-1:0]  pattern_idx;
   logic             done;
   logic [SIG_W-1:0] signature;

   modport master (
      output start, abort, gray_mode, resp,
      input  stim, busy, sample_valid, pattern_idx, done, signature
   );

   modport slave (
      input  start, abort, gray_mode, resp,
      output stim, busy, sample_valid, pattern_idx, done, signature
   );
endinterface

// File: rtl/truth_table_sweeper_misr.sv
// Multiple-input signature register; load (reseed) has priority over en (fold din).
module misr_reg #(
   parameter int               SIG_W = 16,
   parameter logic [SIG_W-1:0] POLY  = '0,
   parameter logic [SIG_W-1:0] SEED  = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic             en,
   input  logic [SIG_W-1:0] din,
   output logic [SIG_W-1:0] sig
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         sig <= SEED;
      else if (load)
         sig <= SEED;
      else if (en)
         sig <= (sig << 1) ^ (sig[SIG_W-1] ? POLY : '0) ^ din;
   end

endmodule

// File: rtl/truth_table_sweeper.sv
// Exhaustive stimulus engine: walks all 2^N_IN patterns (binary or Gray), holds each
// for HOLD cycles and compresses the sampled response into a MISR signature.
module truth_table_sweeper
   import sweeper_pkg::*;
#(
   parameter int               N_IN     = 3,
   parameter int               N_OUT    = 2,
   parameter int               HOLD     = 20,
   parameter int               SIG_W    = 16,
   parameter logic [SIG_W-1:0] SIG_POLY = SIG_W'(DEF_SIG_POLY),
   parameter logic [SIG_W-1:0] SIG_SEED = SIG_W'(DEF_SIG_SEED)
) (
   input logic                  clk,
   input logic                  rst_n,
   truth_table_sweeper_if.slave bus
);

   localparam int P     = 1 << N_IN;
   localparam int IDX_W = N_IN + 1;
   localparam int CNT_W = (HOLD > 1) ? $clog2(HOLD) : 1;

   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(P - 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD - 1);

   state_t            state, state_nxt;
   logic [IDX_W-1:0]  idx, idx_nxt, idx_inc;
   logic [CNT_W-1:0]  hold_cnt, cnt_nxt;
   logic              gray_q, gray_nxt;
   logic [N_IN-1:0]   stim_q, stim_nxt;
   logic              sig_load;
   logic              sample;

   assign idx_inc = idx + IDX_W'(1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         idx      <= '0;
         hold_cnt <= '0;
         gray_q   <= 1'b0;
         stim_q   <= '0;
      end else begin
         state    <= state_nxt;
         idx      <= idx_nxt;
         hold_cnt <= cnt_nxt;
         gray_q   <= gray_nxt;
         stim_q   <= stim_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      idx_nxt   = idx;
      cnt_nxt   = hold_cnt;
      gray_nxt  = gray_q;
      stim_nxt  = stim_q;
      sig_load  = 1'b0;
      sample    = 1'b0;
      case (state)
         IDLE: begin
            stim_nxt = '0;
            if (bus.start) begin
               gray_nxt  = bus.gray_mode;
               idx_nxt   = '0;
               cnt_nxt   = '0;
               sig_load  = 1'b1;
               state_nxt = DRIVE;
            end
         end
         DRIVE: begin
            sample  = (hold_cnt == CNT_LAST);
            cnt_nxt = hold_cnt + CNT_W'(1);
            if (sample) begin
               cnt_nxt = '0;
               if (idx == IDX_LAST) begin
                  state_nxt = DONE;
                  stim_nxt  = '0;
               end else begin
                  idx_nxt  = idx_inc;
                  stim_nxt = gray_q ? N_IN'(bin2gray(32'(idx_inc))) : idx_inc[N_IN-1:0];
               end
            end
            // abort overrides the transition, but a coincident sample still folds in
            if (bus.abort) begin
               state_nxt = IDLE;
               stim_nxt  = '0;
            end
         end
         DONE: begin
            state_nxt = IDLE;
            stim_nxt  = '0;
         end
         default: state_nxt = IDLE;
      endcase
   end

   misr_reg #(
      .SIG_W (SIG_W),
      .POLY  (SIG_POLY),
      .SEED  (SIG_SEED)
   ) u_misr (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (sig_load),
      .en    (sample),
      .din   (SIG_W'(bus.resp)),
      .sig   (bus.signature)
   );

   assign bus.stim         = stim_q;
   assign bus.busy         = (state == DRIVE);
   assign bus.sample_valid = sample;
   assign bus.pattern_idx  = idx[N_IN-1:0];
   assign bus.done         = (state == DONE);

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Self-checking bench: four sweeper configurations against a timing/MISR reference model.
module tb_truth_table_sweeper;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   int unsigned checks   = 0;
   int unsigned failures = 0;

   int unsigned cfg_nin  [4] = '{3, 3, 2, 3};
   int unsigned cfg_nout [4] = '{2, 2, 1, 2};
   int unsigned cfg_hold [4] = '{20, 1, 2, 4};
   int unsigned cfg_w    [4] = '{16, 16, 4, 16};
   logic [31:0] cfg_poly [4] = '{32'h1021, 32'h1021, 32'h3, 32'h1021};
   logic [31:0] cfg_seed [4] = '{32'h0, 32'hACE1, 32'h0, 32'h0};

   truth_table_sweeper_if #(.N_IN(3), .N_OUT(2), .SIG_W(16)) if_a ();
   truth_table_sweeper_if #(.N_IN(3), .N_OUT(2), .SIG_W(16)) if_b ();
   truth_table_sweeper_if #(.N_IN(2), .N_OUT(1), .SIG_W(4))  if_c ();
   truth_table_sweeper_if #(.N_IN(3), .N_OUT(2), .SIG_W(16)) if_d ();

   truth_table_sweeper #(.N_IN(3), .N_OUT(2), .HOLD(20), .SIG_W(16),
                         .SIG_POLY(16'h1021), .SIG_SEED(16'h0000))
      dut_a (.clk(clk), .rst_n(rst_n), .bus(if_a.slave));
   truth_table_sweeper #(.N_IN(3), .N_OUT(2), .HOLD(1), .SIG_W(16),
                         .SIG_POLY(16'h1021), .SIG_SEED(16'hACE1))
      dut_b (.clk(clk), .rst_n(rst_n), .bus(if_b.slave));
   truth_table_sweeper #(.N_IN(2), .N_OUT(1), .HOLD(2), .SIG_W(4),
                         .SIG_POLY(4'h3), .SIG_SEED(4'h0))
      dut_c (.clk(clk), .rst_n(rst_n), .bus(if_c.slave));
   truth_table_sweeper #(.N_IN(3), .N_OUT(2), .HOLD(4), .SIG_W(16),
                         .SIG_POLY(16'h1021), .SIG_SEED(16'h0000))
      dut_d (.clk(clk), .rst_n(rst_n), .bus(if_d.slave));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] misr_next(input logic [31:0] sig, input logic [31:0] din,
                                             input int unsigned w, input logic [31:0] poly);
      logic [31:0] mask;
      logic        msb;
      mask = (32'd1 << w) - 32'd1;
      msb  = sig[w-1];
      return ((sig << 1) ^ (msb ? poly : 32'h0) ^ din) & mask;
   endfunction

   task automatic observe(input int unsigned u,
                          output logic [31:0] o_stim, output logic [31:0] o_busy,
                          output logic [31:0] o_sv, output logic [31:0] o_pidx,
                          output logic [31:0] o_done, output logic [31:0] o_sig);
      case (u)
         0: begin
            o_stim = 32'(if_a.stim); o_busy = 32'(if_a.busy); o_sv = 32'(if_a.sample_valid);
            o_pidx = 32'(if_a.pattern_idx); o_done = 32'(if_a.done); o_sig = 32'(if_a.signature);
         end
         1: begin
            o_stim = 32'(if_b.stim); o_busy = 32'(if_b.busy); o_sv = 32'(if_b.sample_valid);
            o_pidx = 32'(if_b.pattern_idx); o_done = 32'(if_b.done); o_sig = 32'(if_b.signature);
         end
         2: begin
            o_stim = 32'(if_c.stim); o_busy = 32'(if_c.busy); o_sv = 32'(if_c.sample_valid);
            o_pidx = 32'(if_c.pattern_idx); o_done = 32'(if_c.done); o_sig = 32'(if_c.signature);
         end
         default: begin
            o_stim = 32'(if_d.stim); o_busy = 32'(if_d.busy); o_sv = 32'(if_d.sample_valid);
            o_pidx = 32'(if_d.pattern_idx); o_done = 32'(if_d.done); o_sig = 32'(if_d.signature);
         end
      endcase
   endtask

   task automatic drive(input int unsigned u, input logic s, input logic a, input logic g,
                        input logic [31:0] r);
      case (u)
         0: begin if_a.start = s; if_a.abort = a; if_a.gray_mode = g; if_a.resp = r[1:0]; end
         1: begin if_b.start = s; if_b.abort = a; if_b.gray_mode = g; if_b.resp = r[1:0]; end
         2: begin if_c.start = s; if_c.abort = a; if_c.gray_mode = g; if_c.resp = r[0:0]; end
         default: begin if_d.start = s; if_d.abort = a; if_d.gray_mode = g; if_d.resp = r[1:0]; end
      endcase
   endtask

   task automatic chk_reset(input int unsigned u);
      logic [31:0] s, b, v, p, d, g;
      observe(u, s, b, v, p, d, g);
      chk("rst_stim", s, 0);
      chk("rst_busy", b, 0);
      chk("rst_sample_valid", v, 0);
      chk("rst_pattern_idx", p, 0);
      chk("rst_done", d, 0);
      chk("rst_signature", g, cfg_seed[u]);
   endtask

   // resp_mode: 0 random, 1 all ones, 2 all zeros; negative *_t disables that event
   task automatic sweep(input int unsigned u, input logic g, input int resp_mode,
                        input int abort_t, input int restart_t, input int reset_t,
                        input logic abort_with_start);
      int          p_cnt, h, last, k;
      logic [31:0] msig, rv, rmask, e_stim;
      logic [31:0] o_stim, o_busy, o_sv, o_pidx, o_done, o_sig;
      logic        e_busy, e_sv, e_done, idle;
      p_cnt = 1 << cfg_nin[u];
      h     = int'(cfg_hold[u]);
      last  = p_cnt * h;
      rmask = (32'd1 << cfg_nout[u]) - 32'd1;
      msig  = cfg_seed[u];
      idle  = 1'b0;
      @(posedge clk); #1;
      drive(u, 1'b1, abort_with_start, g, $urandom & rmask);
      for (int t = 1; t <= last + 2; t++) begin
         @(posedge clk); #1;
         observe(u, o_stim, o_busy, o_sv, o_pidx, o_done, o_sig);
         e_busy = !idle && (t <= last);
         e_done = !idle && (t == last + 1);
         k      = (t - 1) / h;
         e_stim = e_busy ? (g ? 32'(k ^ (k >> 1)) : 32'(k)) : 32'h0;
         e_sv   = e_busy && (t % h == 0);
         chk("stim", o_stim, e_stim);
         chk("busy", o_busy, 32'(e_busy));
         chk("sample_valid", o_sv, 32'(e_sv));
         chk("done", o_done, 32'(e_done));
         chk("signature", o_sig, msig);
         if (e_busy) chk("pattern_idx", o_pidx, 32'(k));
         if (t == reset_t) begin
            #3 rst_n = 1'b0;
            #1 chk_reset(u);
            @(posedge clk); #1;
            chk_reset(u);
            #3 rst_n = 1'b1;
            drive(u, 1'b0, 1'b0, 1'b0, 32'h0);
            return;
         end
         rv = (resp_mode == 0) ? ($urandom & rmask) : (resp_mode == 1) ? rmask : 32'h0;
         drive(u, t == restart_t, t == abort_t, ~g, rv);
         if (e_sv) msig = misr_next(msig, rv, cfg_w[u], cfg_poly[u]);
         if (t == abort_t && e_busy) idle = 1'b1;
      end
      drive(u, 1'b0, 1'b0, 1'b0, 32'h0);
   endtask

   initial begin
      rst_n = 1'b0;
      for (int unsigned u = 0; u < 4; u++) drive(u, 1'b0, 1'b0, 1'b0, 32'h0);
      repeat (2) @(posedge clk);
      #1;
      for (int unsigned u = 0; u < 4; u++) chk_reset(u);
      @(negedge clk) rst_n = 1'b1;

      sweep(0, 1'b0, 0, -1, -1, -1, 1'b0);
      sweep(0, 1'b1, 0, -1, -1, -1, 1'b0);
      sweep(1, 1'b1, 0, -1, -1, -1, 1'b0);
      sweep(1, 1'b0, 0, -1, -1, -1, 1'b0);

      sweep(2, 1'b0, 1, -1, -1, -1, 1'b0);
      chk("sig_ones_final", 32'(if_c.signature), 32'hF);
      sweep(2, 1'b0, 2, -1, -1, -1, 1'b0);
      chk("sig_zeros_final", 32'(if_c.signature), 32'h0);
      sweep(2, 1'b1, 0, -1, -1, -1, 1'b0);

      sweep(3, 1'b0, 0, 14, -1, -1, 1'b0);
      sweep(3, 1'b0, 0, 16, -1, -1, 1'b0);
      sweep(3, 1'b0, 0, -1, 7, -1, 1'b0);
      sweep(3, 1'b0, 0, -1, 33, -1, 1'b0);
      sweep(3, 1'b1, 0, -1, -1, -1, 1'b1);
      sweep(3, 1'b0, 0, -1, -1, 10, 1'b0);
      sweep(3, 1'b0, 0, -1, -1, -1, 1'b0);
      sweep(3, 1'b1, 0, -1, -1, -1, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/truth_table_sweeper.md
Name: truth_table_sweeper

Overview:
- Synthesisable exhaustive stimulus engine for small combinational DUTs.
- Drives all 2^N_IN input combinations onto `stim`, binary or Gray order, holding each for HOLD cycles.
- Samples the DUT response at the end of each hold and compresses it into a MISR signature; pass/fail is a single compare.
- Sits between the lab control logic and any combinational block under test. Replaces hand-written per-pattern stimulus sequences.

Parameters:
- N_IN, 3, number of DUT inputs; patterns P = 2^N_IN (1..16)
- N_OUT, 2, number of DUT outputs sampled (1..SIG_W)
- HOLD, 20, cycles each pattern is held (>=1)
- SIG_W, 16, MISR width
- SIG_POLY, 16'h1021, MISR feedback taps (XORed when shifted-out MSB is 1)
- SIG_SEED, 0, MISR value loaded on start

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin sweep; sampled only in IDLE
- abort  in  1  terminate sweep; sampled only while busy
- gray_mode  in  1  1 = Gray order, 0 = binary order; captured on start
- resp  in  N_OUT  DUT outputs
- stim  out  N_IN  DUT inputs
- busy  out  1  sweep in progress
- sample_valid  out  1  high in the cycle `resp` is captured
- pattern_idx  out  N_IN  index of the current pattern, binary, pre-encoding
- done  out  1  one-cycle pulse after the last sample
- signature  out  SIG_W  MISR result; held until next start

Behaviour:
- Reset is asynchronous and active-low. While rst_n = 0:
  - state = IDLE
  - stim, pattern_idx, hold_cnt = 0
  - busy, sample_valid, done = 0
  - signature = SIG_SEED
- States: IDLE, DRIVE, DONE.
- IDLE:
  - stim = 0, busy = 0.
  - start = 1 in cycle T0 causes all of the following at the T0 edge: latch gray_mode, idx = 0, hold_cnt = 0, signature = SIG_SEED, go to DRIVE.
- DRIVE:
  - busy = 1.
  - stim = idx in binary mode; stim = idx ^ (idx >> 1) in Gray mode.
  - Registered: stim changes only at the edge where idx changes.
  - hold_cnt increments each cycle.
  - sample_valid = 1 (combinational from state and count) when hold_cnt == HOLD-1. In that cycle:
    - resp is folded into the MISR at the closing edge: sig' = (sig << 1) ^ (sig[MSB] ? SIG_POLY : 0) ^ zero-extended resp.
    - hold_cnt resets to 0.
    - If idx == P-1, go to DONE; otherwise idx increments.
- Pattern k is driven in cycles T0+1+k*HOLD .. T0+(k+1)*HOLD. The last sample is in cycle T0+P*HOLD.
- DONE:
  - Lasts one cycle (T0+P*HOLD+1) with done = 1, busy = 0, stim = 0.
  - Returns to IDLE.
- start while busy or in DONE: ignored.
- abort in DRIVE:
  - Next cycle: IDLE, stim = 0, no done pulse.
  - signature retains the partial value.
  - A sample_valid coinciding with abort is still folded in.
- abort and start asserted together in IDLE: start wins (abort is ignored in IDLE).
- Reset mid-sweep: immediate return to the reset values above, including signature = SIG_SEED.
- idx counter is N_IN+1 bits internally so that P-1 has no wrap hazard. pattern_idx outputs the low N_IN bits.

Decomposition:
- Shared package `sweeper_pkg`:
  - state enum (IDLE, DRIVE, DONE)
  - function bin2gray
  - default SIG_POLY / SIG_SEED constants
- One sub-module `misr_reg`:
  - parameters SIG_W, POLY, SEED
  - ports: clk, rst_n, load, en, din[SIG_W-1:0], sig
  - load has priority over en.

Test Plan:
- Binary sweep, N_IN=3, HOLD=20, start at T0 -> stim steps 0..7, each held exactly 20 cycles. Exactly 8 sample_valid pulses. done high only at T0+161. busy high T0+1..T0+160.
- Gray sweep, N_IN=3, HOLD=1 -> stim sequence 0,1,3,2,6,7,5,4 on consecutive cycles; pattern_idx 0..7.
- Signature check, N_IN=2, N_OUT=1, SIG_W=4, SIG_POLY=4'h3, SIG_SEED=0, resp tied 1 -> signature progresses 1,3,7,F; final 4'hF at done. With resp tied 0, final signature is 4'h0.
- abort asserted while pattern_idx=3 (binary, HOLD=4) -> busy=0 and stim=0 next cycle, no done pulse. signature equals the value after 3 samples.
- start re-pulsed mid-sweep -> no effect: idx, timing and final signature are identical to the unperturbed run.
- rst_n low for 1 cycle mid-sweep, asynchronously between edges -> outputs go to reset values immediately without a clock. The next start produces a full correct sweep.
